load_req_arbiter: RTL and testbench

//  Sits directly downstream of the layer control unit's S_LOAD stage. Captures per-cycle IFM and

---
 rtl/load_req_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_load_req_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_req_arbiter.sv
// Load request arbiter: queues IFM/weight word reads, round-robins them onto one external port
// and writes returned words to local BRAMs. Optional per-channel word counters: LOAD_STATS_EN.
module load_req_arbiter #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned MEM_LAT    = 3,
    parameter int unsigned BUF_AW     = 10,
    parameter logic [31:0] WGT_OFFSET = 32'h0001_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       base_addr,
    input  logic              wr_rd_req_IFM,
    input  logic [31:0]       wr_addr_IFM,
    input  logic              wr_rd_req_Weight,
    input  logic [31:0]       wr_addr_Weight,
    output logic              mem_rd_en,
    output logic [31:0]       mem_rd_addr,
    input  logic              mem_gnt,
    input  logic [31:0]       mem_rd_data,
    output logic              ifm_wr_en,
    output logic [BUF_AW-1:0] ifm_wr_addr,
    output logic [31:0]       ifm_wr_data,
    output logic              wgt_wr_en,
    output logic [BUF_AW-1:0] wgt_wr_addr,
    output logic [31:0]       wgt_wr_data,
    output logic              addr_valid,
    output logic              ovf_err
`ifdef LOAD_STATS_EN
    ,
    output logic [15:0]       ifm_word_cnt,
    output logic [15:0]       wgt_word_cnt
`endif
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = BUF_AW + 32;
    localparam logic [PW:0] PtrOne = 1;

    // Entry layout: {local addr, external addr}; index 0 = IFM, 1 = weight.
    logic [EW-1:0] fifo_mem [2][FIFO_DEPTH];
    logic [PW:0]   wr_ptr_q [2];
    logic [PW:0]   rd_ptr_q [2];
    logic [EW-1:0] push_entry [2];
    logic [EW-1:0] head [2];
    logic [1:0]    push, pop, wr_ok, full, empty;
    logic [EW-1:0] sel_entry;
    logic          sel_wgt, accept, any_push, idle;
    logic          prio_wgt_q, prio_wgt_d;
    logic          ovf_q, ovf_d, seen_q, seen_d, av_q, av_d;

    logic [MEM_LAT-1:0] tag_vld_q, tag_chan_q;
    logic [BUF_AW-1:0]  tag_addr_q [MEM_LAT];

    logic              ifm_wr_en_q, wgt_wr_en_q;
    logic [BUF_AW-1:0] ifm_wr_addr_q, wgt_wr_addr_q;
    logic [31:0]       ifm_wr_data_q, wgt_wr_data_q;
    logic              wb_vld, wb_wgt;

    always_comb begin
        push = {wr_rd_req_Weight, wr_rd_req_IFM};
        push_entry[0] = {wr_addr_IFM[BUF_AW-1:0], base_addr + wr_addr_IFM};
        push_entry[1] = {wr_addr_Weight[BUF_AW-1:0], base_addr + WGT_OFFSET + wr_addr_Weight};
        for (int c = 0; c < 2; c++) begin
            empty[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
            full[c]  = (wr_ptr_q[c][PW] != rd_ptr_q[c][PW]) &&
                       (wr_ptr_q[c][PW-1:0] == rd_ptr_q[c][PW-1:0]);
            head[c]  = fifo_mem[c][rd_ptr_q[c][PW-1:0]];
        end
        mem_rd_en = |(~empty);
        // Weight wins if IFM is empty, or both pending and it is weight's turn.
        sel_wgt   = empty[0] | (~empty[1] & prio_wgt_q);
        accept    = mem_rd_en & mem_gnt;
        pop       = {accept & sel_wgt, accept & ~sel_wgt};
        // A full FIFO popped this cycle frees the slot the push lands in.
        wr_ok     = push & (~full | pop);
        sel_entry = sel_wgt ? head[1] : head[0];
        mem_rd_addr = mem_rd_en ? sel_entry[31:0] : '0;
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (wr_ok[c]) fifo_mem[c][wr_ptr_q[c][PW-1:0]] <= push_entry[c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (wr_ok[c]) wr_ptr_q[c] <= wr_ptr_q[c] + PtrOne;
                if (pop[c])   rd_ptr_q[c] <= rd_ptr_q[c] + PtrOne;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q  <= '0;
            tag_chan_q <= '0;
            for (int i = 0; i < MEM_LAT; i++) tag_addr_q[i] <= '0;
        end else begin
            tag_vld_q[0]  <= accept;
            tag_chan_q[0] <= sel_wgt;
            tag_addr_q[0] <= sel_entry[EW-1:32];
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_chan_q[i] <= tag_chan_q[i-1];
                tag_addr_q[i] <= tag_addr_q[i-1];
            end
        end
    end

    assign wb_vld = tag_vld_q[MEM_LAT-1];
    assign wb_wgt = tag_chan_q[MEM_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifm_wr_en_q   <= 1'b0;
            wgt_wr_en_q   <= 1'b0;
            ifm_wr_addr_q <= '0;
            wgt_wr_addr_q <= '0;
            ifm_wr_data_q <= '0;
            wgt_wr_data_q <= '0;
        end else begin
            ifm_wr_en_q <= wb_vld & ~wb_wgt;
            wgt_wr_en_q <= wb_vld & wb_wgt;
            if (wb_vld && !wb_wgt) begin
                ifm_wr_addr_q <= tag_addr_q[MEM_LAT-1];
                ifm_wr_data_q <= mem_rd_data;
            end
            if (wb_vld && wb_wgt) begin
                wgt_wr_addr_q <= tag_addr_q[MEM_LAT-1];
                wgt_wr_data_q <= mem_rd_data;
            end
        end
    end

    always_comb begin
        any_push   = |push;
        idle       = (&empty) & ~(|tag_vld_q);
        prio_wgt_d = accept ? ~sel_wgt : prio_wgt_q;
        ovf_d      = ovf_q | (|(push & ~wr_ok));
        seen_d     = seen_q | any_push;
        av_d       = av_q;
        if (any_push)          av_d = 1'b0;
        else if (idle && seen_q) av_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_wgt_q <= 1'b0;
            ovf_q      <= 1'b0;
            seen_q     <= 1'b0;
            av_q       <= 1'b0;
        end else begin
            prio_wgt_q <= prio_wgt_d;
            ovf_q      <= ovf_d;
            seen_q     <= seen_d;
            av_q       <= av_d;
        end
    end

`ifdef LOAD_STATS_EN
    logic [15:0] ifm_cnt_q, wgt_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifm_cnt_q <= '0;
            wgt_cnt_q <= '0;
        end else if (any_push && av_q) begin
            ifm_cnt_q <= '0;
            wgt_cnt_q <= '0;
        end else begin
            if (ifm_wr_en_q && ifm_cnt_q != 16'hFFFF) ifm_cnt_q <= ifm_cnt_q + 16'd1;
            if (wgt_wr_en_q && wgt_cnt_q != 16'hFFFF) wgt_cnt_q <= wgt_cnt_q + 16'd1;
        end
    end

    assign ifm_word_cnt = ifm_cnt_q;
    assign wgt_word_cnt = wgt_cnt_q;
`endif

    assign ifm_wr_en   = ifm_wr_en_q;
    assign ifm_wr_addr = ifm_wr_addr_q;
    assign ifm_wr_data = ifm_wr_data_q;
    assign wgt_wr_en   = wgt_wr_en_q;
    assign wgt_wr_addr = wgt_wr_addr_q;
    assign wgt_wr_data = wgt_wr_data_q;
    assign addr_valid  = av_q;
    assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_load_req_arbiter.sv
// Self-checking bench for load_req_arbiter: fixed-latency memory model plus per-channel
// writeback scoreboards and an issue-order queue.
module tb_load_req_arbiter;

    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned MEM_LAT    = 3;
    localparam int unsigned BUF_AW     = 10;
    localparam logic [31:0] WGT_OFFSET = 32'h0001_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       base_addr = '0;
    logic              wr_rd_req_IFM = 1'b0;
    logic [31:0]       wr_addr_IFM = '0;
    logic              wr_rd_req_Weight = 1'b0;
    logic [31:0]       wr_addr_Weight = '0;
    logic              mem_rd_en;
    logic [31:0]       mem_rd_addr;
    logic              mem_gnt = 1'b0;
    logic [31:0]       mem_rd_data;
    logic              ifm_wr_en, wgt_wr_en, addr_valid, ovf_err;
    logic [BUF_AW-1:0] ifm_wr_addr, wgt_wr_addr;
    logic [31:0]       ifm_wr_data, wgt_wr_data;
`ifdef LOAD_STATS_EN
    logic [15:0]       ifm_word_cnt, wgt_word_cnt;
`endif

    int total = 0;
    int bad = 0;
    int ifm_wr_cnt = 0;
    int wgt_wr_cnt = 0;
    bit issue_chk = 0;
    logic [BUF_AW+31:0] ifm_q[$];
    logic [BUF_AW+31:0] wgt_q[$];
    logic [31:0]        issue_q[$];
    logic [BUF_AW+31:0] exp_i, exp_w;
    logic [31:0]        exp_a;
    logic [31:0]        mem_pipe [MEM_LAT];

    load_req_arbiter #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .MEM_LAT(MEM_LAT),
        .BUF_AW(BUF_AW),
        .WGT_OFFSET(WGT_OFFSET)
    ) dut (
        .clk(clk),
        .rst(rst),
        .base_addr(base_addr),
        .wr_rd_req_IFM(wr_rd_req_IFM),
        .wr_addr_IFM(wr_addr_IFM),
        .wr_rd_req_Weight(wr_rd_req_Weight),
        .wr_addr_Weight(wr_addr_Weight),
        .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_gnt(mem_gnt),
        .mem_rd_data(mem_rd_data),
        .ifm_wr_en(ifm_wr_en),
        .ifm_wr_addr(ifm_wr_addr),
        .ifm_wr_data(ifm_wr_data),
        .wgt_wr_en(wgt_wr_en),
        .wgt_wr_addr(wgt_wr_addr),
        .wgt_wr_data(wgt_wr_data),
        .addr_valid(addr_valid),
        .ovf_err(ovf_err)
`ifdef LOAD_STATS_EN
        ,
        .ifm_word_cnt(ifm_word_cnt),
        .wgt_word_cnt(wgt_word_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // External memory: word for an accepted address appears exactly MEM_LAT cycles later.
    always @(posedge clk) begin
        for (int i = MEM_LAT - 1; i > 0; i--) mem_pipe[i] <= mem_pipe[i-1];
        mem_pipe[0] <= (mem_rd_en && mem_gnt) ? mem_fn(mem_rd_addr) : 32'hDEAD_BEEF;
    end
    assign mem_rd_data = mem_pipe[MEM_LAT-1];

    always @(negedge clk) begin
        if (ifm_wr_en) begin
            ifm_wr_cnt++;
            total++;
            if (ifm_q.size() == 0) begin
                bad++;
                $display("FAIL ifm_write: got addr=%0h data=%h, required no write",
                         ifm_wr_addr, ifm_wr_data);
            end else begin
                exp_i = ifm_q.pop_front();
                if ({ifm_wr_addr, ifm_wr_data} !== exp_i) begin
                    bad++;
                    $display("FAIL ifm_write: got %h, required %h", {ifm_wr_addr, ifm_wr_data},
                             exp_i);
                end
            end
        end
        if (wgt_wr_en) begin
            wgt_wr_cnt++;
            total++;
            if (wgt_q.size() == 0) begin
                bad++;
                $display("FAIL wgt_write: got addr=%0h data=%h, required no write",
                         wgt_wr_addr, wgt_wr_data);
            end else begin
                exp_w = wgt_q.pop_front();
                if ({wgt_wr_addr, wgt_wr_data} !== exp_w) begin
                    bad++;
                    $display("FAIL wgt_write: got %h, required %h", {wgt_wr_addr, wgt_wr_data},
                             exp_w);
                end
            end
        end
        if (issue_chk && mem_rd_en && mem_gnt) begin
            total++;
            if (issue_q.size() == 0) begin
                bad++;
                $display("FAIL issue_order: got %h, required no issue", mem_rd_addr);
            end else begin
                exp_a = issue_q.pop_front();
                if (mem_rd_addr !== exp_a) begin
                    bad++;
                    $display("FAIL issue_order: got %h, required %h", mem_rd_addr, exp_a);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_rd_req_IFM = 1'b0;
        wr_rd_req_Weight = 1'b0;
        issue_chk = 0;
        ifm_q.delete();
        wgt_q.delete();
        issue_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive(input bit ri, input logic [31:0] ai, input bit ki,
                         input bit rw, input logic [31:0] aw, input bit kw);
        wr_rd_req_IFM = ri;
        wr_addr_IFM = ai;
        wr_rd_req_Weight = rw;
        wr_addr_Weight = aw;
        if (ri && ki) ifm_q.push_back({ai[BUF_AW-1:0], mem_fn(base_addr + ai)});
        if (rw && kw) wgt_q.push_back({aw[BUF_AW-1:0], mem_fn(base_addr + WGT_OFFSET + aw)});
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        @(negedge clk);
        while (!addr_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (addr_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_done: addr_valid=%b after %0d cycles, required 1", name,
                     addr_valid, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({mem_rd_en, ifm_wr_en, wgt_wr_en, addr_valid, ovf_err, mem_rd_addr, ifm_wr_addr,
             ifm_wr_data, wgt_wr_addr, wgt_wr_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: en=%b%b%b av=%b ovf=%b addr=%h, required all 0",
                     mem_rd_en, ifm_wr_en, wgt_wr_en, addr_valid, ovf_err, mem_rd_addr);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({addr_valid, mem_rd_en} !== 2'b00) begin
                bad++;
                $display("FAIL reset_idle: av=%b rd_en=%b, required 0 0", addr_valid, mem_rd_en);
            end
        end
    endtask

    task automatic test_ifm_only();
        do_reset();
        base_addr = 32'h100;
        mem_gnt = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            step();
            drive(c < 4, 32'(c), 1, 0, 0, 0);
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                total++;
                if ({mem_rd_en, mem_rd_addr} !== {1'b1, 32'h100 + 32'(c - 1)}) begin
                    bad++;
                    $display("FAIL ifm_issue c%0d: got en=%b addr=%h, required 1 %h", c,
                             mem_rd_en, mem_rd_addr, 32'h100 + 32'(c - 1));
                end
            end
            if (c >= 5 && c <= 8) begin
                total++;
                if ({ifm_wr_en, ifm_wr_addr, ifm_wr_data} !==
                    {1'b1, 10'(c - 5), mem_fn(32'h100 + 32'(c - 5))}) begin
                    bad++;
                    $display("FAIL ifm_wb c%0d: got en=%b addr=%0h, required 1 %0h", c,
                             ifm_wr_en, ifm_wr_addr, c - 5);
                end
            end
            if (c == 8 || c == 9) begin
                total++;
                if (addr_valid !== (c == 9)) begin
                    bad++;
                    $display("FAIL ifm_addr_valid c%0d: got %b, required %b", c, addr_valid,
                             c == 9);
                end
            end
        end
    endtask

    task automatic test_interleave();
        int i0, w0;
        do_reset();
        base_addr = 32'h100;
        mem_gnt = 1'b1;
        issue_chk = 1;
        i0 = ifm_wr_cnt;
        w0 = wgt_wr_cnt;
        for (int c = 0; c < 4; c++) begin
            step();
            drive(1, 32'(c), 1, 1, 32'(c), 1);
            issue_q.push_back(32'h0000_0100 + 32'(c));
            issue_q.push_back(32'h0001_0100 + 32'(c));
        end
        step();
        drive(0, 0, 0, 0, 0, 0);
        wait_done(50, "interleave");
        total++;
        if ({ovf_err, 32'(ifm_wr_cnt - i0), 32'(wgt_wr_cnt - w0), 32'(issue_q.size())} !==
            {1'b0, 32'd4, 32'd4, 32'd0}) begin
            bad++;
            $display("FAIL interleave_counts: ovf=%b ifm=%0d wgt=%0d left=%0d, required 0 4 4 0",
                     ovf_err, ifm_wr_cnt - i0, wgt_wr_cnt - w0, issue_q.size());
        end
        issue_chk = 0;
    endtask

    task automatic test_overflow();
        int i0, w0;
        do_reset();
        base_addr = 32'h4000;
        mem_gnt = 1'b0;
        i0 = ifm_wr_cnt;
        w0 = wgt_wr_cnt;
        for (int c = 0; c <= FIFO_DEPTH; c++) begin
            step();
            drive(1, 32'(c), c < FIFO_DEPTH, 1, 32'(c + 100), c < FIFO_DEPTH);
        end
        step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++;
        if ({ovf_err, mem_rd_en} !== 2'b11) begin
            bad++;
            $display("FAIL ovf_flag: got ovf=%b rd_en=%b, required 1 1", ovf_err, mem_rd_en);
        end
        step();
        mem_gnt = 1'b1;
        wait_done(200, "overflow");
        total++;
        if ({32'(ifm_wr_cnt - i0), 32'(wgt_wr_cnt - w0), ovf_err} !==
            {32'd16, 32'd16, 1'b1}) begin
            bad++;
            $display("FAIL ovf_drain: ifm=%0d wgt=%0d ovf=%b, required 16 16 1",
                     ifm_wr_cnt - i0, wgt_wr_cnt - w0, ovf_err);
        end
    endtask

    task automatic test_full_push_pop();
        int i0;
        do_reset();
        base_addr = 32'h8000;
        mem_gnt = 1'b0;
        i0 = ifm_wr_cnt;
        for (int c = 0; c < FIFO_DEPTH; c++) begin
            step();
            drive(1, 32'(c), 1, 0, 0, 0);
        end
        step();
        mem_gnt = 1'b1;
        drive(1, 32'(FIFO_DEPTH), 1, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        wait_done(100, "fullpp");
        total++;
        if ({ovf_err, 32'(ifm_wr_cnt - i0)} !== {1'b0, 32'd17}) begin
            bad++;
            $display("FAIL fullpp: ovf=%b ifm=%0d, required 0 17", ovf_err, ifm_wr_cnt - i0);
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        base_addr = 32'h2000;
        mem_gnt = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            drive(1, 32'(c), 0, 0, 0, 0);
        end
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({mem_rd_en, ifm_wr_en, wgt_wr_en, addr_valid, ovf_err, mem_rd_addr} !== '0) begin
            bad++;
            $display("FAIL rst_inflight_outputs: en=%b%b%b av=%b ovf=%b addr=%h, required 0",
                     mem_rd_en, ifm_wr_en, wgt_wr_en, addr_valid, ovf_err, mem_rd_addr);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({ifm_wr_en, wgt_wr_en, mem_rd_en, addr_valid} !== 4'b0000) begin
                bad++;
                $display("FAIL rst_inflight_quiet: wr=%b%b rd_en=%b av=%b, required 0",
                         ifm_wr_en, wgt_wr_en, mem_rd_en, addr_valid);
            end
        end
    endtask

`ifdef LOAD_STATS_EN
    task automatic test_stats();
        do_reset();
        base_addr = 32'h300;
        mem_gnt = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            drive(1, 32'(c), 1, c < 6, 32'(c), 1);
        end
        step();
        drive(0, 0, 0, 0, 0, 0);
        wait_done(60, "stats");
        total++;
        if ({ifm_word_cnt, wgt_word_cnt} !== {16'd10, 16'd6}) begin
            bad++;
            $display("FAIL stats_count: got %0d %0d, required 10 6", ifm_word_cnt, wgt_word_cnt);
        end
        step();
        drive(1, 32'd50, 1, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++;
        if ({ifm_word_cnt, wgt_word_cnt, addr_valid} !== 33'd0) begin
            bad++;
            $display("FAIL stats_clear: got %0d %0d av=%b, required 0 0 0", ifm_word_cnt,
                     wgt_word_cnt, addr_valid);
        end
        wait_done(30, "stats_tail");
    endtask
`endif

    initial begin
        test_reset();
        test_ifm_only();
        test_interleave();
        test_overflow();
        test_full_push_pop();
        test_reset_inflight();
`ifdef LOAD_STATS_EN
        test_stats();
`endif
        total++;
        if ((ifm_q.size() + wgt_q.size()) != 0) begin
            bad++;
            $display("FAIL leftover_expected: got %0d pending, required 0",
                     ifm_q.size() + wgt_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
